// File: rtl/arb_pkg.sv
// Shared types and default sizing for the request/grant arbiter.
// State encoding and parameter defaults used by the top and the bench.
package arb_pkg;

  typedef enum logic {
    IDLE,
    OWNED
  } arb_state_e;

  localparam int N_DEF        = 4;
  localparam int MAX_HOLD_DEF = 8;

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: rotate requests by ptr, then take the lowest set bit.
// Purely combinational; idx is only meaningful while valid is high.
module rr_priority_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 valid,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW-1:0]  off;
  logic [IW:0]    sum;

  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[N-1:0];
    off = '0;
    // Walk downwards so the lowest set bit wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = IW'(i);
    end
    sum = {1'b0, off} + {1'b0, ptr};
    if (sum >= (IW + 1)'(N)) sum = sum - (IW + 1)'(N);
    idx = sum[IW-1:0];
  end

  assign valid = |req;

endmodule

// File: rtl/req_gnt_arbiter.sv
// Round-robin request/grant arbiter with a bounded hold time.
// An owner keeps the grant until it drops its request or hits MAX_HOLD.
module req_gnt_arbiter
  import arb_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         request,
  output logic [N-1:0]         grant,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 timeout_err
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(MAX_HOLD);

  arb_state_e    state;
  logic [IW-1:0] owner;
  logic [IW-1:0] ptr;
  logic [IW-1:0] nxt_ptr;
  logic [IW-1:0] pick_idx;
  logic          pick_valid;
  logic [CW-1:0] hold;
  logic          own_req;
  logic          hold_max;

  rr_priority_pick #(
    .N(N)
  ) u_pick (
    .req  (request),
    .ptr  (ptr),
    .valid(pick_valid),
    .idx  (pick_idx)
  );

  assign own_req  = request[owner];
  assign hold_max = (hold == CW'(MAX_HOLD - 1));
  assign nxt_ptr  = (owner == IW'(N - 1)) ? '0 : owner + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= '0;
      ptr         <= '0;
      hold        <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            state <= OWNED;
            owner <= pick_idx;
            hold  <= '0;
          end
        end
        OWNED: begin
          // A voluntary drop wins over the hold limit on the same edge.
          if (!own_req) begin
            state <= IDLE;
            ptr   <= nxt_ptr;
            hold  <= '0;
          end else if (hold_max) begin
            state       <= IDLE;
            ptr         <= nxt_ptr;
            hold        <= '0;
            timeout_err <= 1'b1;
          end else begin
            hold <= hold + 1'b1;
          end
        end
      endcase
    end
  end

  // Masking by live request keeps grant[i] -> request[i] within the cycle.
  always_comb begin
    grant = '0;
    if (state == OWNED) grant[owner] = request[owner];
  end

  assign grant_valid = |grant;
  assign grant_id    = grant_valid ? owner : '0;

endmodule

// File: tb/tb_req_gnt_arbiter.sv
// Directed bench for req_gnt_arbiter (N=4, MAX_HOLD=8).
// Expected outputs are queued at drive time and checked at the negedge.
module tb_req_gnt_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] request;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic       timeout_err;

  int ntest = 0;
  int nfail = 0;

  typedef struct packed {
    logic [3:0] g;
    logic       to;
  } exp_t;

  exp_t sb[$];

  req_gnt_arbiter #(
    .N(4),
    .MAX_HOLD(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .request    (request),
    .grant      (grant),
    .grant_valid(grant_valid),
    .grant_id   (grant_id),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  property p_inv;
    @(posedge clk) disable iff (!rst_n)
      ((grant & ~request) == 4'b0) && $onehot0(grant) &&
      (grant_valid == (|grant));
  endproperty

  a_inv: assert property (p_inv)
    else begin
      nfail++;
      $error("FAIL inv grant=%b request=%b valid=%b",
             grant, request, grant_valid);
    end

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (g[i]) r = 2'(i);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [3:0] eg,
                     input logic eto);
    logic [1:0] eid;
    eid = idx_of(eg);
    ntest++;
    assert (grant === eg) else begin
      nfail++;
      $error("FAIL %s grant got=%b exp=%b", tag, grant, eg);
    end
    ntest++;
    assert (grant_valid === (|eg)) else begin
      nfail++;
      $error("FAIL %s valid got=%b exp=%b", tag, grant_valid, |eg);
    end
    ntest++;
    assert (grant_id === eid) else begin
      nfail++;
      $error("FAIL %s id got=%0d exp=%0d", tag, grant_id, eid);
    end
    ntest++;
    assert (timeout_err === eto) else begin
      nfail++;
      $error("FAIL %s timeout got=%b exp=%b", tag, timeout_err, eto);
    end
  endtask

  // One cycle: drive after the edge, queue expectation, check at negedge.
  task automatic cyc(input string tag, input logic [3:0] req,
                     input logic [3:0] eg, input logic eto);
    exp_t e;
    @(posedge clk);
    #1;
    request = req;
    sb.push_back('{g: eg, to: eto});
    @(negedge clk);
    if (sb.size() == 0) begin
      nfail++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      chk(tag, e.g, e.to);
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    request = 4'b0;
    rst_n   = 1'b0;
    #1;
    chk(tag, 4'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] oh;
    rst_n   = 1'b0;
    request = 4'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset", 4'b0, 1'b0);
    rst_n = 1'b1;

    // Single requester, latency and release
    cyc("a_idle0", 4'b0000, 4'b0000, 1'b0);
    cyc("a_req", 4'b0001, 4'b0000, 1'b0);
    cyc("a_g0", 4'b0001, 4'b0001, 1'b0);
    cyc("a_g1", 4'b0001, 4'b0001, 1'b0);
    cyc("a_g2", 4'b0001, 4'b0001, 1'b0);
    cyc("a_drop", 4'b0000, 4'b0000, 1'b0);
    cyc("a_idle1", 4'b0000, 4'b0000, 1'b0);
    // ptr is now 1: requester 1 must beat requester 0
    cyc("a_ptr_i", 4'b0011, 4'b0000, 1'b0);
    cyc("a_ptr_g", 4'b0011, 4'b0010, 1'b0);
    cyc("a_ptr_d", 4'b0000, 4'b0000, 1'b0);
    cyc("a_ptr_e", 4'b0000, 4'b0000, 1'b0);

    // Full contention, each owner releases after two cycles
    do_reset("b_rst");
    cyc("b_idle", 4'b1111, 4'b0000, 1'b0);
    for (int k = 0; k < 5; k++) begin
      oh = 4'b0001 << (k % 4);
      cyc("b_g0", 4'b1111, oh, 1'b0);
      cyc("b_g1", 4'b1111, oh, 1'b0);
      cyc("b_drop", 4'b1111 & ~oh, 4'b0000, 1'b0);
      cyc("b_idle", (k == 4) ? 4'b0000 : 4'b1111, 4'b0000, 1'b0);
    end
    cyc("b_end", 4'b0000, 4'b0000, 1'b0);

    // Hold-limit timeout with a persistent requester
    do_reset("c_rst");
    cyc("c_idle", 4'b0100, 4'b0000, 1'b0);
    repeat (8) cyc("c_hold1", 4'b0100, 4'b0100, 1'b0);
    cyc("c_to1", 4'b0100, 4'b0000, 1'b1);
    repeat (8) cyc("c_hold2", 4'b0100, 4'b0100, 1'b0);
    cyc("c_to2", 4'b0100, 4'b0000, 1'b1);
    cyc("c_regnt", 4'b0100, 4'b0100, 1'b0);
    cyc("c_drop", 4'b0000, 4'b0000, 1'b0);
    cyc("c_quiet", 4'b0000, 4'b0000, 1'b0);

    // Drop on the same edge the hold limit is reached
    do_reset("d_rst");
    cyc("d_idle", 4'b0010, 4'b0000, 1'b0);
    repeat (7) cyc("d_hold", 4'b0010, 4'b0010, 1'b0);
    cyc("d_drop", 4'b0000, 4'b0000, 1'b0);
    cyc("d_no_to", 4'b0000, 4'b0000, 1'b0);
    cyc("d_quiet", 4'b0000, 4'b0000, 1'b0);

    // Asynchronous reset in the middle of an ownership
    cyc("e_idle", 4'b0001, 4'b0000, 1'b0);
    cyc("e_g", 4'b0001, 4'b0001, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("e_async", 4'b0000, 1'b0);
    request = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("e_req", 4'b1010, 4'b0000, 1'b0);
    cyc("e_g1", 4'b1010, 4'b0010, 1'b0);
    cyc("e_drop", 4'b0000, 4'b0000, 1'b0);
    cyc("e_end", 4'b0000, 4'b0000, 1'b0);

    if (sb.size() != 0) begin
      nfail++;
      $error("FAIL sb_left got=%0d exp=0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule

// File: doc/req_gnt_arbiter.md
REQ_GNT_ARBITER -- requirements
Module: req_gnt_arbiter

Interface
REQ-001 Parameter N, default 4, number of requesters (2..16).
REQ-002 Parameter MAX_HOLD, default 8, maximum consecutive cycles one owner may hold a grant (2..255).
REQ-003 The block SHALL have a single clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  sole clock; all state SHALL update on posedge clk.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 request  input  N  per-requester request level, held high while service is wanted.
REQ-007 grant  output  N  one-hot (or zero) grant to the current owner.
REQ-008 grant_valid  output  1  high when any grant bit is high.
REQ-009 grant_id  output  $clog2(N)  index of the current owner; 0 when grant_valid is low.
REQ-010 timeout_err  output  1  one-cycle pulse when an owner is forcibly released at MAX_HOLD.

Function
REQ-011 The FSM SHALL have two states, IDLE and OWNED.
REQ-012 In IDLE with request != 0 at a posedge, the block SHALL select an owner round-robin, starting at index ptr, and enter OWNED.
REQ-013 In IDLE with request == 0, the FSM SHALL remain in IDLE.
REQ-014 ptr SHALL reset to 0 and, on every release, load (owner+1) mod N (wrap N-1 -> 0).
REQ-015 grant SHALL equal onehot(owner) AND request while in OWNED, and 0 in IDLE.
REQ-016 Grant masking is combinational, so grant is never high while the owner's request is low (invariant: grant[i] -> request[i]).
REQ-017 Latency: a request sampled high at edge k in IDLE SHALL produce grant high after edge k (visible during cycle k+1).
REQ-018 In OWNED, if request[owner] is sampled low, the FSM SHALL return to IDLE and update ptr; no new owner is chosen on that edge (one idle cycle between owners).
REQ-019 Hold counter SHALL clear on entry to OWNED and increment each OWNED cycle; when it reaches MAX_HOLD-1 with request[owner] still high, the FSM SHALL return to IDLE, update ptr and pulse timeout_err for exactly one cycle.
REQ-020 If request[owner] drops on the same edge the counter hits MAX_HOLD-1, this is a normal release and timeout_err SHALL stay low.
REQ-021 Requests from non-owners while in OWNED SHALL be ignored until the next IDLE arbitration, with no loss of fairness.
REQ-022 At most one grant bit SHALL be high in any cycle.

Reset
REQ-023 While rst_n is low: state=IDLE, ptr=0, hold counter=0, grant=0, grant_valid=0, grant_id=0, timeout_err=0.
REQ-024 Reset asserted during OWNED SHALL drop grant asynchronously, without waiting for a clock edge.
REQ-025 The first arbitration after reset release SHALL start at index 0.

Structure
REQ-026 Package arb_pkg SHALL hold the state enum typedef (IDLE, OWNED) and the default N/MAX_HOLD localparams.
REQ-027 Round-robin selection SHALL be a combinational sub-module rr_priority_pick (inputs req[N], ptr; outputs valid and idx), built as a rotate followed by a priority encoder.

Verification (N=4, MAX_HOLD=8)
REQ-028 request=4'b0001 from cycle 2 -> grant=4'b0001 and grant_id=0 from cycle 3; request drops at cycle 6 -> grant=0 in cycle 6 and ptr=1.
REQ-029 request=4'b1111 held with each owner releasing after 2 cycles -> grants in order 0,1,2,3,0, with one idle cycle between owners.
REQ-030 request=4'b0100 held for 20 cycles -> grant held for 8 cycles, timeout_err pulses once, then IDLE for 1 cycle, then re-granted to 2.
REQ-031 Owner 1 drops its request on the same edge the counter reaches 7 -> release with no timeout_err.
REQ-032 rst_n pulled low mid-OWNED between edges -> grant=0 immediately; after release, request=4'b1010 -> first grant goes to 1.
REQ-033 The bench SHALL run a concurrent assertion on every posedge: grant[i] -> request[i], $onehot0(grant), and grant_valid == |grant.
